// File: rtl/accel_pkg.sv
// Shared types and defaults for the image accelerator sequencer.
// Latency: n/a (types, constants and a pure byte function).
// Backpressure: n/a.
package accel_pkg;

    localparam int IMG_WORDS_DEF = 25344;
    localparam int OUT_BASE_DEF  = 25344;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_COPY   = 2'd0,
        OP_INVERT = 2'd1,
        OP_THRESH = 2'd2,
        OP_HALVE  = 2'd3
    } op_t;

    function automatic logic [7:0] byte_op(input op_t op, input logic [7:0] p, input logic [7:0] thr);
        logic [7:0] res;
        case (op)
            OP_COPY:   res = p;
            OP_INVERT: res = ~p;
            OP_THRESH: res = (p >= thr) ? 8'hFF : 8'h00;
            default:   res = {1'b0, p[7:1]};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pixel_op.sv
// Per-word pixel transform: applies the selected byte operation to all four bytes.
// Latency: combinational.
// Backpressure: none.
module pixel_op
    import accel_pkg::*;
(
    input  logic [31:0] in_word,
    input  op_t         op,
    input  logic [7:0]  thr,
    output logic [31:0] out_word
);

    // Bytes are independent lanes; no carry crosses a byte boundary.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign out_word[8*k +: 8] = byte_op(op, in_word[8*k +: 8], thr);
    end

endmodule

// File: rtl/accel_seq.sv
// Image accelerator sequencer: streams IMG_WORDS words through pixel_op into the output region.
// Latency: 2 cycles per word (read, write); 2*IMG_WORDS cycles from first read to done.
// Backpressure: none; memory must accept one access per cycle with read data the next cycle.
module accel_seq
    import accel_pkg::*;
#(
    parameter int IMG_WORDS = IMG_WORDS_DEF,
    parameter int OUT_BASE  = OUT_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  thr,
    output logic        busy,
    output logic        done,
    output logic        en,
    output logic        we,
    output logic [15:0] addr,
    output logic [31:0] dataW,
    input  logic [31:0] dataR,
    output logic        dump_image
);

    localparam logic [15:0] LAST_IDX   = 16'(IMG_WORDS - 1);
    localparam logic [15:0] OUT_BASE_A = 16'(OUT_BASE);

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    op_t         op_q, op_d;
    logic [7:0]  thr_q, thr_d;
    logic [31:0] xform_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= OP_COPY;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            thr_q   <= thr_d;
        end
    end

    // op/thr are captured only on an accepted start so mid-run changes are invisible.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        thr_d   = thr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_t'(op);
                    thr_d   = thr;
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    pixel_op u_pixel_op (
        .in_word  (dataR),
        .op       (op_q),
        .thr      (thr_q),
        .out_word (xform_dat)
    );

    // Bus is decoded purely from the state register; idle bus is held at zero.
    always_comb begin
        en    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        dataW = '0;
        case (state_q)
            ST_READ: begin
                en   = 1'b1;
                addr = idx_q;
            end
            ST_WRITE: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = OUT_BASE_A + idx_q;
                dataW = xform_dat;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign dump_image = (state_q == ST_DONE);

endmodule

// File: tb/tb_accel_seq.sv
// Bench for accel_seq: synchronous memory model, access-trace scoreboard and directed runs.
// Latency: n/a.
// Backpressure: n/a.
module tb_accel_seq;

    localparam int N  = 25344;
    localparam int OB = 25344;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [7:0]  thr   = 8'd0;
    logic        busy, done, en, we, dump_image;
    logic [15:0] addr;
    logic [31:0] dataW;
    logic [31:0] dataR = 32'h0;

    accel_seq #(.IMG_WORDS(N), .OUT_BASE(OB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .thr        (thr),
        .busy       (busy),
        .done       (done),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .dataW      (dataW),
        .dataR      (dataR),
        .dump_image (dump_image)
    );

    always #5 clk = ~clk;

    logic [31:0] in_mem  [0:N-1];
    logic [31:0] out_mem [0:N-1];
    logic        clr_out = 1'b0;

    always @(posedge clk) begin
        if (en && !we)
            dataR <= (int'(addr) < N) ? in_mem[int'(addr)] : 32'hBAD0BAD0;
        if (clr_out) begin
            for (int k = 0; k < 8; k++) out_mem[k] <= 32'hDEADBEEF;
        end else if (en && we && int'(addr) >= OB && int'(addr) < OB + N) begin
            out_mem[int'(addr) - OB] <= dataW;
        end
    end

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] dat;
    } acc_t;

    acc_t        exp_q[$];
    logic [16:0] acc_log[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_cycles = 0;
    int          done_entries = 0;
    logic        done_prev = 1'b0;
    int          base_busy, base_done, base_acc;

    function automatic logic [31:0] f_model(input int o, input logic [31:0] w, input int t);
        logic [31:0] r;
        int p, q;
        r = 32'h0;
        for (int k = 0; k < 4; k++) begin
            p = int'((w >> (8 * k)) & 32'hFF);
            case (o)
                0:       q = p;
                1:       q = 255 - p;
                2:       q = (p >= t) ? 255 : 0;
                default: q = p / 2;
            endcase
            r = r | (32'(q) << (8 * k));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Every cycle: each memory access must be the next one the model expects.
    always @(negedge clk) begin
        acc_t e;
        if (rst_n) begin
            if (busy) busy_cycles++;
            if (done && !done_prev) done_entries++;
            if (en) begin
                acc_log.push_back({we, addr});
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL access_unexpected: got we=%0b addr=%0d, required no access", we, addr);
                end else begin
                    e = exp_q.pop_front();
                    if (we !== e.we || addr !== e.addr || (e.we && dataW !== e.dat)) begin
                        errors++;
                        $display("FAIL access: got we=%0b addr=%0d data=%h required we=%0b addr=%0d data=%h",
                                 we, addr, dataW, e.we, e.addr, e.dat);
                    end
                end
            end else begin
                checks++;
                if (we !== 1'b0 || addr !== 16'h0 || dataW !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_bus: got we=%0b addr=%0d data=%h required 0 0 0", we, addr, dataW);
                end
            end
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap: got busy=1 done=1 required not both");
            end
        end
        done_prev = done;
    end

    task automatic pulse_start(input int o, input int t);
        acc_t a;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            a.we = 1'b0; a.addr = 16'(i);      a.dat = 32'h0;
            exp_q.push_back(a);
            a.we = 1'b1; a.addr = 16'(OB + i); a.dat = f_model(o, in_mem[i], t);
            exp_q.push_back(a);
        end
        base_busy = busy_cycles;
        base_done = done_entries;
        base_acc  = acc_log.size();
        op    = 2'(o);
        thr   = 8'(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = ~op;
        thr   = ~thr;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk(tag, {busy, done, en, we, dump_image, addr, dataW}, 64'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs four words, then aborts with reset while the fifth read is on the bus.
    task automatic partial_run(input int o, input int t);
        @(negedge clk);
        clr_out = 1'b1;
        @(negedge clk);
        clr_out = 1'b0;
        pulse_start(o, t);
        repeat (8) @(negedge clk);
        #1;
        do_reset("partial_reset_outputs");
    endtask

    initial begin
        int found;
        int bad;
        for (int i = 0; i < N; i++) in_mem[i] = (i * 32'h9E3779B9) ^ 32'(i << 7);
        in_mem[0] = 32'h00FF1080;
        in_mem[1] = 32'h7F80FF00;
        in_mem[2] = 32'h01FF0203;
        in_mem[3] = 32'h12345678;

        #2;
        chk("reset_outputs", {busy, done, en, we, dump_image, addr, dataW}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {busy, done, en, dump_image}, 64'h0);

        chk("model_invert", f_model(1, 32'h00FF1080, 0),   32'hFF00EF7F);
        chk("model_thresh", f_model(2, 32'h7F80FF00, 128), 32'h00FFFF00);
        chk("model_halve",  f_model(3, 32'h01FF0203, 0),   32'h007F0101);

        partial_run(2, 8'h80);
        chk("thresh_word1", out_mem[1], 32'h00FFFF00);
        partial_run(3, 0);
        chk("halve_word2", out_mem[2], 32'h007F0101);
        partial_run(0, 0);
        for (int k = 0; k < 4; k++) chk("copy_word", out_mem[k], in_mem[k]);

        // Abort at word 100: bus must drop in the same cycle, no access afterwards.
        pulse_start(1, 0);
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
            @(negedge clk);
            if (en && !we && addr == 16'd100) found = 1;
        end
        chk("reached_word100", found, 1);
        #1;
        do_reset("abort_word100_outputs");
        repeat (4) @(negedge clk);
        chk("idle_after_abort", {busy, done, en}, 64'h0);

        // Full run with a stray start and op/thr change at cycle 10.
        pulse_start(1, 0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = 2'd2;
        thr   = 8'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60000 && !done; c++) @(negedge clk);
        #1;
        chk("done_reached", done, 1);
        chk("run_length", busy_cycles - base_busy, 50688);
        chk("done_entries", done_entries - base_done, 1);
        chk("dump_image", dump_image, 1);
        chk("en_in_done", {en, busy}, 64'h0);
        chk("accesses_left", exp_q.size(), 0);
        chk("access_count", acc_log.size() - base_acc, 50688);
        chk("first_access_r0",     acc_log[base_acc],     {1'b0, 16'd0});
        chk("second_access_w25344", acc_log[base_acc + 1], {1'b1, 16'd25344});
        chk("third_access_r1",     acc_log[base_acc + 2], {1'b0, 16'd1});
        chk("last_access_w50687",  acc_log[acc_log.size() - 1], {1'b1, 16'd50687});

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("still_done", {done, dump_image, busy, en}, 64'hC);
        chk("single_done_entry", done_entries - base_done, 1);

        bad = 0;
        for (int i = 0; i < N; i++) if (out_mem[i] !== ~in_mem[i]) bad++;
        chk("out_region_bad_words", bad, 0);
        chk("invert_word0_full", out_mem[0], 32'hFF00EF7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
